// File: rtl/mdio_arbiter.sv
// mdio_arbiter: round-robin sharing of one clause-22 MDIO master among N_REQ requesters.
// Optional MDIO_ARB_PRIO_EN gives requester 0 fixed highest priority.
module mdio_arbiter #(
    parameter int N_REQ       = 4,
    parameter int TIMEOUT_CYC = 1024
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [N_REQ-1:0]     req_valid,
    input  logic [32*N_REQ-1:0]  req_frame,
    output logic [N_REQ-1:0]     req_grant,
    output logic [N_REQ-1:0]     req_done,
    output logic                 req_err,
    output logic [15:0]          req_rd_data,
    output logic                 mst_start,
    output logic [31:0]          mst_t_data,
    input  logic                 mst_data_rdy,
    input  logic [15:0]          mst_rd_data
);
    localparam int W  = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam int TW = $clog2(TIMEOUT_CYC + 1);
    localparam logic [N_REQ-1:0] ONE = N_REQ'(1);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;

    state_t         state, state_n;
    logic [W-1:0]   rr_ptr, rr_n, win, win_n, pick;
    logic [TW-1:0]  timer, timer_n;
    logic [31:0]    frame_n;
    logic           err_n, any, frame_ok, is_read;
    logic [15:0]    rd_n;

    assign is_read   = mst_t_data[29:28] == 2'b10;
    assign frame_ok  = mst_t_data[31:30] == 2'b01 && (mst_t_data[29:28] == 2'b01 || is_read);
    assign mst_start = state == ISSUE && frame_ok;
    assign req_grant = state != IDLE ? ONE << win : '0;
    assign req_done  = state == DONE ? ONE << win : '0;

    // Winner selection: first pending requester at or after rr_ptr, wrapping.
    always_comb begin
        pick = rr_ptr;
        any  = 1'b0;
        for (int i = 0; i < N_REQ; i++) begin
            if (!any && req_valid[(int'(rr_ptr) + i) % N_REQ]) begin
                pick = W'((int'(rr_ptr) + i) % N_REQ);
                any  = 1'b1;
            end
        end
`ifdef MDIO_ARB_PRIO_EN
        if (req_valid[0]) pick = '0;
`endif
    end

    // Next-state logic: grant, issue, wait for completion or timeout, report.
    always_comb begin
        state_n = state;
        rr_n    = rr_ptr;
        win_n   = win;
        timer_n = timer;
        frame_n = mst_t_data;
        err_n   = req_err;
        rd_n    = req_rd_data;
        case (state)
            IDLE: if (any) begin
                win_n   = pick;
                frame_n = req_frame[32*int'(pick) +: 32];
                state_n = ISSUE;
            end
            ISSUE: if (!frame_ok) begin
                err_n   = 1'b1;
                rd_n    = '0;
                state_n = DONE;
            end else begin
                timer_n = TW'(TIMEOUT_CYC);
                state_n = WAIT;
            end
            WAIT: if (mst_data_rdy) begin
                err_n   = 1'b0;
                rd_n    = is_read ? mst_rd_data : '0;
                state_n = DONE;
            end else if (timer == '0) begin
                err_n   = 1'b1;
                rd_n    = '0;
                state_n = DONE;
            end else begin
                timer_n = timer - 1'b1;
            end
            default: begin
`ifdef MDIO_ARB_PRIO_EN
                if (win != '0) rr_n = (win == W'(N_REQ - 1)) ? '0 : win + 1'b1;
`else
                rr_n = (win == W'(N_REQ - 1)) ? '0 : win + 1'b1;
`endif
                state_n = IDLE;
            end
        endcase
    end

    // State register; reset aborts any transaction without a done pulse.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state       <= IDLE;
            rr_ptr      <= '0;
            win         <= '0;
            timer       <= '0;
            mst_t_data  <= '0;
            req_err     <= 1'b0;
            req_rd_data <= '0;
        end else begin
            state       <= state_n;
            rr_ptr      <= rr_n;
            win         <= win_n;
            timer       <= timer_n;
            mst_t_data  <= frame_n;
            req_err     <= err_n;
            req_rd_data <= rd_n;
        end
    end
endmodule

// File: tb/tb_mdio_arbiter.sv
// tb_mdio_arbiter: directed bench for mdio_arbiter.
module tb_mdio_arbiter;
    localparam int N = 4;
    localparam int T = 32;

    logic           clk = 1'b0;
    logic           reset = 1'b0;
    logic [N-1:0]   req_valid = '0;
    logic [32*N-1:0] req_frame = '0;
    logic [N-1:0]   req_grant, req_done;
    logic           req_err;
    logic [15:0]    req_rd_data;
    logic           mst_start;
    logic [31:0]    mst_t_data;
    logic           mst_data_rdy = 1'b0;
    logic [15:0]    mst_rd_data = '0;
    int checks = 0;
    int failures = 0;

    mdio_arbiter #(.N_REQ(N), .TIMEOUT_CYC(T)) dut (
        .clk(clk), .reset(reset), .req_valid(req_valid), .req_frame(req_frame),
        .req_grant(req_grant), .req_done(req_done), .req_err(req_err),
        .req_rd_data(req_rd_data), .mst_start(mst_start), .mst_t_data(mst_t_data),
        .mst_data_rdy(mst_data_rdy), .mst_rd_data(mst_rd_data)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] mk(input logic [1:0] st, input logic [1:0] op, input logic [15:0] d);
        return {st, op, 5'd3, 5'd1, 2'b10, d};
    endfunction

    task automatic pulse_reset();
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        reset = 1'b1;
    endtask

    task automatic test_reset();
        reset = 1'b0;
        repeat (2) @(negedge clk);
        checks++; if (req_grant !== '0) begin failures++; $display("FAIL reset_grant got=%h exp=0", req_grant); end
        checks++; if (req_done !== '0) begin failures++; $display("FAIL reset_done got=%h exp=0", req_done); end
        checks++; if (mst_start !== 1'b0 || req_err !== 1'b0) begin failures++; $display("FAIL reset_start_err got=%b%b exp=00", mst_start, req_err); end
        checks++; if (mst_t_data !== '0 || req_rd_data !== '0) begin failures++; $display("FAIL reset_data got=%h/%h exp=0/0", mst_t_data, req_rd_data); end
        reset = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_single_read();
        int starts;
        req_frame[63:32] = 32'h60A20000;
        req_valid = 4'b0010;
        @(negedge clk);
        checks++; if (mst_start !== 1'b1) begin failures++; $display("FAIL rd_start got=%b exp=1", mst_start); end
        checks++; if (req_grant !== 4'b0010) begin failures++; $display("FAIL rd_grant got=%b exp=0010", req_grant); end
        checks++; if (mst_t_data !== 32'h60A20000) begin failures++; $display("FAIL rd_tdata got=%h exp=60a20000", mst_t_data); end
        starts = 1;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            if (mst_start) starts++;
        end
        mst_data_rdy = 1'b1;
        mst_rd_data = 16'hBEEF;
        @(negedge clk);
        mst_data_rdy = 1'b0;
        req_valid = '0;
        checks++; if (req_done !== 4'b0010) begin failures++; $display("FAIL rd_done got=%b exp=0010", req_done); end
        checks++; if (req_err !== 1'b0) begin failures++; $display("FAIL rd_err got=%b exp=0", req_err); end
        checks++; if (req_rd_data !== 16'hBEEF) begin failures++; $display("FAIL rd_data got=%h exp=beef", req_rd_data); end
        @(negedge clk);
        checks++; if (req_done !== '0 || req_grant !== '0) begin failures++; $display("FAIL rd_after got=%b/%b exp=0000/0000", req_done, req_grant); end
        checks++; if (starts != 1) begin failures++; $display("FAIL rd_starts got=%0d exp=1", starts); end
    endtask

    task automatic test_round_robin();
        logic [3:0] e;
        logic got;
        pulse_reset();
        for (int i = 0; i < N; i++) req_frame[32*i +: 32] = mk(2'b01, 2'b10, 16'h0);
        req_valid = 4'hF;
        for (int t = 0; t < 5; t++) begin
            e = 4'(1 << (t % 4));
            got = 1'b0;
            for (int c = 0; c < 10 && !got; c++) begin
                @(negedge clk);
                if ($countones(req_grant) > 1) begin
                    checks++; failures++; $display("FAIL rr_onehot got=%b exp=onehot", req_grant);
                end
                if (mst_start) got = 1'b1;
            end
            checks++; if (!got) begin failures++; $display("FAIL rr_start_seen got=0 exp=1 txn=%0d", t); end
            checks++; if (req_grant !== e) begin failures++; $display("FAIL rr_grant got=%b exp=%b txn=%0d", req_grant, e, t); end
            @(negedge clk);
            checks++; if (mst_start !== 1'b0) begin failures++; $display("FAIL rr_start_once got=%b exp=0", mst_start); end
            mst_data_rdy = 1'b1;
            mst_rd_data = 16'h1000 + 16'(t);
            @(negedge clk);
            mst_data_rdy = 1'b0;
            checks++; if (req_done !== e) begin failures++; $display("FAIL rr_done got=%b exp=%b", req_done, e); end
            checks++; if (req_rd_data !== 16'h1000 + 16'(t)) begin failures++; $display("FAIL rr_data got=%h exp=%h", req_rd_data, 16'h1000 + 16'(t)); end
        end
        req_valid = '0;
        @(negedge clk);
    endtask

    task automatic test_bad_frame();
        req_frame[95:64] = mk(2'b00, 2'b10, 16'h5555);
        req_valid = 4'b0100;
        @(negedge clk);
        checks++; if (mst_start !== 1'b0) begin failures++; $display("FAIL bad_start got=%b exp=0", mst_start); end
        checks++; if (req_grant !== 4'b0100) begin failures++; $display("FAIL bad_grant got=%b exp=0100", req_grant); end
        @(negedge clk);
        req_valid = '0;
        checks++; if (req_done !== 4'b0100) begin failures++; $display("FAIL bad_done got=%b exp=0100", req_done); end
        checks++; if (req_err !== 1'b1) begin failures++; $display("FAIL bad_err got=%b exp=1", req_err); end
        checks++; if (req_rd_data !== 16'h0) begin failures++; $display("FAIL bad_data got=%h exp=0", req_rd_data); end
        @(negedge clk);
    endtask

    task automatic test_timeout();
        logic early;
        req_frame[127:96] = mk(2'b01, 2'b10, 16'h0);
        req_valid = 4'b1000;
        @(negedge clk);
        checks++; if (mst_start !== 1'b1) begin failures++; $display("FAIL to_start got=%b exp=1", mst_start); end
        early = 1'b0;
        for (int n = 1; n <= T + 1; n++) begin
            @(negedge clk);
            if (req_done !== '0) early = 1'b1;
        end
        checks++; if (early !== 1'b0) begin failures++; $display("FAIL to_early got=1 exp=0"); end
        @(negedge clk);
        req_valid = '0;
        checks++; if (req_done !== 4'b1000) begin failures++; $display("FAIL to_done got=%b exp=1000", req_done); end
        checks++; if (req_err !== 1'b1) begin failures++; $display("FAIL to_err got=%b exp=1", req_err); end
        @(negedge clk);
    endtask

    task automatic test_timeout_race();
        req_frame[31:0] = mk(2'b01, 2'b10, 16'h0);
        req_valid = 4'b0001;
        @(negedge clk);
        checks++; if (mst_start !== 1'b1) begin failures++; $display("FAIL race_start got=%b exp=1", mst_start); end
        repeat (T + 1) @(negedge clk);
        mst_data_rdy = 1'b1;
        mst_rd_data = 16'h1234;
        @(negedge clk);
        mst_data_rdy = 1'b0;
        req_valid = '0;
        checks++; if (req_done !== 4'b0001) begin failures++; $display("FAIL race_done got=%b exp=0001", req_done); end
        checks++; if (req_err !== 1'b0) begin failures++; $display("FAIL race_err got=%b exp=0", req_err); end
        checks++; if (req_rd_data !== 16'h1234) begin failures++; $display("FAIL race_data got=%h exp=1234", req_rd_data); end
        @(negedge clk);
        mst_data_rdy = 1'b1;
        repeat (2) @(negedge clk);
        mst_data_rdy = 1'b0;
        checks++; if (req_done !== '0 || req_grant !== '0) begin failures++; $display("FAIL idle_rdy got=%b/%b exp=0000/0000", req_done, req_grant); end
    endtask

    task automatic test_reset_mid();
        logic got;
        logic saw_done;
        req_frame[63:32] = mk(2'b01, 2'b10, 16'h0);
        req_frame[127:96] = mk(2'b01, 2'b01, 16'hA5A5);
        req_valid = 4'b0010;
        repeat (2) @(negedge clk);
        req_valid = 4'b1010;
        #2 reset = 1'b0;
        #1;
        checks++; if (req_grant !== '0 || mst_start !== 1'b0) begin failures++; $display("FAIL rst_async got=%b/%b exp=0000/0", req_grant, mst_start); end
        checks++; if (mst_t_data !== '0) begin failures++; $display("FAIL rst_tdata got=%h exp=0", mst_t_data); end
        req_valid = 4'b1000;
        saw_done = 1'b0;
        repeat (2) begin
            @(negedge clk);
            if (req_done !== '0) saw_done = 1'b1;
        end
        checks++; if (saw_done !== 1'b0) begin failures++; $display("FAIL rst_no_done got=1 exp=0"); end
        reset = 1'b1;
        got = 1'b0;
        for (int c = 0; c < 10 && !got; c++) begin
            @(negedge clk);
            if (mst_start) got = 1'b1;
        end
        checks++; if (!got || req_grant !== 4'b1000) begin failures++; $display("FAIL rst_next got=%b/%b exp=1/1000", got, req_grant); end
        @(negedge clk);
        mst_data_rdy = 1'b1;
        @(negedge clk);
        mst_data_rdy = 1'b0;
        req_valid = '0;
        checks++; if (req_done !== 4'b1000 || req_rd_data !== 16'h0) begin failures++; $display("FAIL rst_wr_done got=%b/%h exp=1000/0000", req_done, req_rd_data); end
        @(negedge clk);
    endtask

    task automatic test_prio();
        logic [3:0] e;
        logic got;
        pulse_reset();
        for (int i = 0; i < N; i++) req_frame[32*i +: 32] = mk(2'b01, 2'b01, 16'h0);
        req_valid = 4'hF;
        for (int t = 0; t < 4; t++) begin
`ifdef MDIO_ARB_PRIO_EN
            e = 4'b0001;
`else
            e = 4'(1 << t);
`endif
            got = 1'b0;
            for (int c = 0; c < 10 && !got; c++) begin
                @(negedge clk);
                if (mst_start) got = 1'b1;
            end
            checks++; if (!got || req_grant !== e) begin failures++; $display("FAIL prio_grant got=%b/%b exp=1/%b txn=%0d", got, req_grant, e, t); end
            @(negedge clk);
            mst_data_rdy = 1'b1;
            @(negedge clk);
            mst_data_rdy = 1'b0;
            checks++; if (req_done !== e) begin failures++; $display("FAIL prio_done got=%b exp=%b", req_done, e); end
        end
        req_valid = '0;
        repeat (2) @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_single_read();
        test_round_robin();
        test_bad_frame();
        test_timeout();
        test_timeout_race();
        test_reset_mid();
        test_prio();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
